// File: rtl/btn_evt_pkg.sv
// rtl/btn_evt_pkg.sv - shared widths, repeat-FSM states and the empty-event constant
package btn_evt_pkg;

  localparam int unsigned BTN_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam logic [BTN_W-1:0] NO_EVT = '0;

endpackage

// File: rtl/btn_evt_fifo.sv
// rtl/btn_evt_fifo.sv - small event FIFO with registered read port; a pop on empty is ignored
module btn_evt_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             do_pop, do_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign dout  = dout_q;

  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/btn_evt_queue.sv
// rtl/btn_evt_queue.sv - button press/auto-repeat event queue with start/done read handshake
// Auto-repeat is built only when BTN_EVT_REPEAT_EN is defined.
module btn_evt_queue
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_port,
  input  logic [BTN_W-1:0] btn,
  output logic             done_port,
  output logic [BTN_W-1:0] out1
);

  logic [BTN_W-1:0] prev_q;
  logic [BTN_W-1:0] press, rpt, evt;
  logic             done_q, hit_q;
  logic [BTN_W-1:0] fifo_dout;
  logic             fifo_empty, fifo_full_unused;

  assign press = btn & ~prev_q;
  assign evt   = press | rpt;

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any change of the held vector restarts the full initial delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpt     = NO_EVT;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (btn != NO_EVT) state_d = DELAY;
      end
      DELAY, REPEAT: begin
        if (btn == NO_EVT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (btn != prev_q) begin
          state_d = DELAY;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == DELAY) ? DLY_LAST : PER_LAST)) begin
          rpt     = btn;
          state_d = REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic rpt_cfg_unused;

  assign rpt            = NO_EVT;
  assign rpt_cfg_unused = ^{REPEAT_DELAY, REPEAT_PERIOD, CNT_W};
`endif

  btn_evt_fifo #(
    .WIDTH(BTN_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (evt != NO_EVT),
    .din  (evt),
    .pop  (start_port),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full_unused)
  );

  // The FIFO read register only moves on a real pop, so it doubles as the held result.
  assign done_port = done_q;
  assign out1      = hit_q ? fifo_dout : NO_EVT;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q <= NO_EVT;
      done_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      prev_q <= btn;
      done_q <= start_port;
      if (start_port) hit_q <= ~fifo_empty;
    end
  end

endmodule

// File: tb/tb_btn_evt_queue.sv
// tb/tb_btn_evt_queue.sv - randomized and directed bench for btn_evt_queue against a queue-based event model
module tb_btn_evt_queue;

  localparam int DEPTH = 4;
  localparam int RD    = 8;
  localparam int RP    = 4;
`ifdef BTN_EVT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_port = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       done_port;
  logic [3:0] out1;

  int n_vec = 0;
  int n_bad = 0;

  logic [3:0] q[$];
  logic [3:0] m_prev = 4'b0;
  logic [3:0] m_out = 4'b0;
  int         m_held = 0;

  btn_evt_queue #(
    .DEPTH(DEPTH),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start_port(start_port),
    .btn(btn),
    .done_port(done_port),
    .out1(out1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a held vector repeats at RD cycles after it appears, then every RP cycles.
  task automatic step(input logic [3:0] b, input logic s);
    logic [3:0] press, rpt, evt;
    @(negedge clock);
    btn = b;
    start_port = s;
    press = b & ~m_prev;
    if (b != 4'b0 && b == m_prev) m_held++;
    else m_held = 0;
    rpt = (REP_EN && b != 4'b0 && m_held >= RD && ((m_held - RD) % RP) == 0) ? b : 4'b0;
    evt = press | rpt;
    if (s) m_out = (q.size() > 0) ? q.pop_front() : 4'b0;
    if (evt != 4'b0 && q.size() < DEPTH) q.push_back(evt);
    m_prev = b;
    @(posedge clock);
    #1;
    chk("done", {31'b0, done_port}, {31'b0, s});
    chk("out1", {28'b0, out1}, {28'b0, m_out});
  endtask

  task automatic reset_now();
    reset = 1'b0;
    btn = 4'b0;
    start_port = 1'b0;
    q.delete();
    m_prev = 4'b0;
    m_held = 0;
    m_out = 4'b0;
    #1;
    chk("rst_done", {31'b0, done_port}, 32'd0);
    chk("rst_out1", {28'b0, out1}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int hits;
    int hold_left;
    logic [3:0] rb;

    #2;
    chk("init_done", {31'b0, done_port}, 32'd0);
    chk("init_out1", {28'b0, out1}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // press held 3 cycles, two reads
    step(4'b0000, 0);
    repeat (3) step(4'b0001, 0);
    step(4'b0000, 0);
    step(4'b0000, 1);
    chk("s1_first", {28'b0, out1}, 32'h1);
    step(4'b0000, 0);
    step(4'b0000, 1);
    chk("s1_second", {28'b0, out1}, 32'h0);

    // long hold, then five back-to-back reads
    repeat (20) step(4'b0100, 0);
    step(4'b0000, 0);
    hits = 0;
    repeat (5) begin
      step(4'b0000, 1);
      if (out1 == 4'b0100) hits++;
    end
    chk("s2_hits", hits, REP_EN ? 32'd4 : 32'd1);
    chk("s2_last", {28'b0, out1}, 32'h0);

    // six presses without reads: last two dropped
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 4'b0001 : 4'b0010, 0);
      step(4'b0000, 0);
    end
    repeat (5) step(4'b0000, 1);

    // full FIFO plus a press in the read cycle
    step(4'b0001, 0); step(4'b0000, 0);
    step(4'b0010, 0); step(4'b0000, 0);
    step(4'b0100, 0); step(4'b0000, 0);
    step(4'b1000, 0); step(4'b0000, 0);
    step(4'b0001, 1);
    chk("s5_head", {28'b0, out1}, 32'h1);
    repeat (4) step(4'b0000, 1);
    chk("s5_new", {28'b0, out1}, 32'h1);
    step(4'b0000, 1);

    // reset mid-hold with queued events and a pending done
    step(4'b0001, 0); step(4'b0000, 0);
    step(4'b0010, 0); step(4'b0000, 0);
    step(4'b0100, 0);
    step(4'b0100, 1);
    #2;
    reset_now();
    step(4'b0000, 1);
    chk("s6_empty", {28'b0, out1}, 32'h0);
    step(4'b1000, 0);
    step(4'b0000, 1);
    chk("s6_new", {28'b0, out1}, 32'h8);

    // randomized holds and reads
    hold_left = 0;
    rb = 4'b0;
    for (int i = 0; i < 500; i++) begin
      if (hold_left == 0) begin
        rb = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
        hold_left = $urandom_range(1, 16);
      end
      hold_left--;
      step(rb, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
